// File: rtl/alu_wide_sequencer.sv
// Runs 32-bit operations on a shared 16-bit ALU as two sequenced passes.
// The ALU's own flag register carries carry / shifted-out bit between
// passes. The 32-bit result and flags are presented with a valid/ready response.
module alu_wide_sequencer #(
    parameter int unsigned FS_WIDTH = 5,
    parameter int unsigned W        = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          req_op_i,
    input  logic [2*W-1:0]      req_a_i,
    input  logic [2*W-1:0]      req_b_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [2*W-1:0]      rsp_result_o,
    output logic [3:0]          rsp_flags_o,
    output logic [W-1:0]        alu_a_o,
    output logic [W-1:0]        alu_b_o,
    output logic [FS_WIDTH-1:0] alu_funsel_o,
    output logic                alu_wf_o,
    input  logic [W-1:0]        alu_out_i,
    input  logic [3:0]          alu_flags_i
);

    localparam int unsigned DW = 2 * W;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_LSL  = 3'd6;
    localparam logic [2:0] OP_LSR  = 3'd7;

    localparam logic [FS_WIDTH-1:0] FS_IDLE = FS_WIDTH'(5'b10000);
    localparam logic [FS_WIDTH-1:0] FS_NOTA = FS_WIDTH'(5'b10010);
    localparam logic [FS_WIDTH-1:0] FS_ADD  = FS_WIDTH'(5'b10100);
    localparam logic [FS_WIDTH-1:0] FS_ADDC = FS_WIDTH'(5'b10101);
    localparam logic [FS_WIDTH-1:0] FS_AND  = FS_WIDTH'(5'b10111);
    localparam logic [FS_WIDTH-1:0] FS_OR   = FS_WIDTH'(5'b11000);
    localparam logic [FS_WIDTH-1:0] FS_XOR  = FS_WIDTH'(5'b11001);
    localparam logic [FS_WIDTH-1:0] FS_LSL  = FS_WIDTH'(5'b11011);
    localparam logic [FS_WIDTH-1:0] FS_LSR  = FS_WIDTH'(5'b11100);
    localparam logic [FS_WIDTH-1:0] FS_CSL  = FS_WIDTH'(5'b11110);
    localparam logic [FS_WIDTH-1:0] FS_CSR  = FS_WIDTH'(5'b11111);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DW-1:0]         a_q, a_d;
    logic [DW-1:0]         b_q, b_d;
    logic [DW-1:0]         result_q, result_d;
    logic                  z_lo_q, z_lo_d;
    logic [W-1:0]          alu_a_q, alu_a_d;
    logic [W-1:0]          alu_b_q, alu_b_d;
    logic [FS_WIDTH-1:0]   alu_funsel_q, alu_funsel_d;
    logic                  alu_wf_q, alu_wf_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  hi_first;

    // FunSel used on the first pass of each operation
    function automatic logic [FS_WIDTH-1:0] fs_first(input logic [2:0] op);
        case (op)
            OP_ADD:  return FS_ADD;
            OP_ADC:  return FS_ADDC;
            OP_AND:  return FS_AND;
            OP_OR:   return FS_OR;
            OP_XOR:  return FS_XOR;
            OP_NOTA: return FS_NOTA;
            OP_LSL:  return FS_LSL;
            OP_LSR:  return FS_LSR;
            default: return FS_IDLE;
        endcase
    endfunction

    // FunSel used on the second pass; arithmetic and shifts chain through the ALU C flag
    function automatic logic [FS_WIDTH-1:0] fs_second(input logic [2:0] op);
        case (op)
            OP_ADD:  return FS_ADDC;
            OP_ADC:  return FS_ADDC;
            OP_AND:  return FS_AND;
            OP_OR:   return FS_OR;
            OP_XOR:  return FS_XOR;
            OP_NOTA: return FS_NOTA;
            OP_LSL:  return FS_CSL;
            OP_LSR:  return FS_CSR;
            default: return FS_IDLE;
        endcase
    endfunction

    // Next-state, datapath capture, and the ALU drive for the upcoming cycle
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        z_lo_d       = z_lo_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_funsel_d = FS_IDLE;
        alu_wf_d     = 1'b0;
        hi_first     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    op_d    = req_op_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    state_d = S_P1;
                end
            end
            S_P1: begin
                // LSR walks high word first so the shifted-out bit feeds the low word
                if (op_q == OP_LSR) begin
                    result_d[DW-1:W] = alu_out_i;
                end else begin
                    result_d[W-1:0]  = alu_out_i;
                end
                z_lo_d  = (alu_out_i == '0);
                state_d = S_P2;
            end
            S_P2: begin
                if (op_q == OP_LSR) begin
                    result_d[W-1:0]  = alu_out_i;
                end else begin
                    result_d[DW-1:W] = alu_out_i;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        hi_first = (op_d == OP_LSR);

        case (state_d)
            S_P1: begin
                alu_wf_d     = 1'b1;
                alu_funsel_d = fs_first(op_d);
                alu_a_d      = hi_first ? a_d[DW-1:W] : a_d[W-1:0];
                alu_b_d      = hi_first ? b_d[DW-1:W] : b_d[W-1:0];
            end
            S_P2: begin
                alu_wf_d     = 1'b1;
                alu_funsel_d = fs_second(op_d);
                alu_a_d      = hi_first ? a_d[W-1:0] : a_d[DW-1:W];
                alu_b_d      = hi_first ? b_d[W-1:0] : b_d[DW-1:W];
            end
            default: ;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            z_lo_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_funsel_q <= FS_IDLE;
            alu_wf_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            z_lo_q       <= z_lo_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_funsel_q <= alu_funsel_d;
            alu_wf_q     <= alu_wf_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = result_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_funsel_o = alu_funsel_q;
    assign alu_wf_o     = alu_wf_q;

    // Flags come straight from the ALU's flag register, which is frozen while wf is low in DONE
    assign rsp_flags_o  = {z_lo_q & alu_flags_i[3], alu_flags_i[2:0]};

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: a 16-bit ALU model sits on the ALU port and a
// 32-bit reference model predicts the wide result and flags.
module tb_alu_wide_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_funsel;
    logic        alu_wf;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags_q = 4'b0000;

    int passes = 0;
    int checks = 0;

    // Reference-model persistent flags (the ALU keeps C and O across logic ops)
    logic m_c = 1'b0;
    logic m_o = 1'b0;

    logic [31:0] res, er;
    logic [3:0]  fl, ef;
    int          lat;
    logic [4:0]  fs1, fs2;

    alu_wide_sequencer #(.FS_WIDTH(5), .W(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_flags_o  (rsp_flags),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_funsel_o (alu_funsel),
        .alu_wf_o     (alu_wf),
        .alu_out_i    (alu_out),
        .alu_flags_i  (alu_flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit ALU model: combinational result, flags {Z,C,N,O} registered on wf
    logic        cin, c_n, o_n;
    logic [16:0] sum17;
    logic [3:0]  flags_n;
    always_comb begin
        cin     = alu_flags_q[2];
        alu_out = alu_a;
        c_n     = cin;
        o_n     = alu_flags_q[0];
        sum17   = '0;
        case (alu_funsel)
            5'b10100, 5'b10101: begin
                sum17   = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_funsel == 5'b10101) ? 17'(cin) : 17'd0);
                alu_out = sum17[15:0];
                c_n     = sum17[16];
                o_n     = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
            end
            5'b10111: alu_out = alu_a & alu_b;
            5'b11000: alu_out = alu_a | alu_b;
            5'b11001: alu_out = alu_a ^ alu_b;
            5'b10010: alu_out = ~alu_a;
            5'b11011: begin alu_out = {alu_a[14:0], 1'b0}; c_n = alu_a[15]; end
            5'b11110: begin alu_out = {alu_a[14:0], cin};  c_n = alu_a[15]; end
            5'b11100: begin alu_out = {1'b0, alu_a[15:1]}; c_n = alu_a[0];  end
            5'b11111: begin alu_out = {cin, alu_a[15:1]};  c_n = alu_a[0];  end
            default: ;
        endcase
        flags_n = {alu_out == 16'h0000, c_n, alu_out[15], o_n};
    end

    always @(posedge clk) begin
        if (alu_wf) alu_flags_q <= flags_n;
    end

    // 32-bit reference: plain wide arithmetic on the whole operands
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f);
        logic [32:0] s;
        logic c, o;
        c = m_c;
        o = m_o;
        r = '0;
        case (op)
            3'd0, 3'd1: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 3'd1) ? 33'(m_c) : 33'd0);
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = a << 1; c = a[31]; end
            default: begin r = a >> 1; c = a[0]; end
        endcase
        m_c = c;
        m_o = o;
        f = {r == 32'h0, c, r[31], o};
    endtask

    // Drives one request through a full handshake; records P1/P2 FunSel and latency
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        ref_op(op, a, b, er, ef);
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        fs1 = alu_funsel;
        fs2 = 5'b00000;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) fs2 = alu_funsel;
        end
        res = rsp_result;
        fl  = rsp_flags;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else passes++;
        checks++; if (rsp_result !== 32'h0) $display("FAIL rst_result got %h exp 0", rsp_result); else passes++;
        checks++; if (alu_wf !== 1'b0) $display("FAIL rst_alu_wf got %b exp 0", alu_wf); else passes++;
        checks++; if (alu_funsel !== 5'b10000) $display("FAIL rst_funsel got %b exp 10000", alu_funsel); else passes++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset during P2 of an ADD: no response must appear
        ref_op(3'd0, 32'h1234_5678, 32'h1111_1111, er, ef);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (alu_funsel !== 5'b10101) $display("FAIL midrst_in_p2 funsel got %b exp 10101", alu_funsel); else passes++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (req_ready !== 1'b1) $display("FAIL midrst_req_ready got %b exp 1", req_ready); else passes++;
        checks++; if (alu_wf !== 1'b0) $display("FAIL midrst_alu_wf got %b exp 0", alu_wf); else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL midrst_rsp_valid got %b exp 0", rsp_valid); else passes++;
    endtask

    task automatic test_add();
        do_op(3'd0, 32'h0001_FFFF, 32'h0000_0001);
        checks++; if (res !== 32'h0002_0000) $display("FAIL add1_result got %h exp 00020000", res); else passes++;
        checks++; if (fl[3:1] !== 3'b000) $display("FAIL add1_zcn got %b exp 000", fl[3:1]); else passes++;
        checks++; if (fs1 !== 5'b10100) $display("FAIL add1_p1_funsel got %b exp 10100", fs1); else passes++;
        checks++; if (fs2 !== 5'b10101) $display("FAIL add1_p2_funsel got %b exp 10101", fs2); else passes++;
        checks++; if (lat !== 2) $display("FAIL add1_latency got %0d exp 2", lat); else passes++;
        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        checks++; if (res !== 32'h0000_0000) $display("FAIL add2_result got %h exp 00000000", res); else passes++;
        checks++; if (fl[3:2] !== 2'b11) $display("FAIL add2_zc got %b exp 11", fl[3:2]); else passes++;
        do_op(3'd1, 32'h0000_0001, 32'h0000_0001);
        checks++; if (res !== 32'h0000_0003) $display("FAIL adc_result got %h exp 00000003", res); else passes++;
        checks++; if (fl[3] !== 1'b0) $display("FAIL adc_z got %b exp 0", fl[3]); else passes++;
    endtask

    task automatic test_shift();
        do_op(3'd6, 32'h8000_8000, 32'h0000_0000);
        checks++; if (res !== 32'h0001_0000) $display("FAIL lsl_result got %h exp 00010000", res); else passes++;
        checks++; if (fl[3:2] !== 2'b01) $display("FAIL lsl_zc got %b exp 01", fl[3:2]); else passes++;
        checks++; if (fs1 !== 5'b11011 || fs2 !== 5'b11110) $display("FAIL lsl_funsel got %b/%b exp 11011/11110", fs1, fs2); else passes++;
        do_op(3'd7, 32'h0001_0001, 32'h0000_0000);
        checks++; if (res !== 32'h0000_8000) $display("FAIL lsr_result got %h exp 00008000", res); else passes++;
        checks++; if (fl[2] !== 1'b1) $display("FAIL lsr_c got %b exp 1", fl[2]); else passes++;
        checks++; if (fs1 !== 5'b11100 || fs2 !== 5'b11111) $display("FAIL lsr_funsel got %b/%b exp 11100/11111", fs1, fs2); else passes++;
    endtask

    task automatic test_logic();
        do_op(3'd4, 32'h1234_0000, 32'h1234_0000);
        checks++; if (res !== 32'h0) $display("FAIL xor_result got %h exp 00000000", res); else passes++;
        checks++; if (fl[3] !== 1'b1) $display("FAIL xor_z got %b exp 1", fl[3]); else passes++;
        do_op(3'd2, 32'hFFFF_0000, 32'h0F0F_0000);
        checks++; if (res !== 32'h0F0F_0000) $display("FAIL and_result got %h exp 0f0f0000", res); else passes++;
        checks++; if (fl[3] !== 1'b0) $display("FAIL and_z got %b exp 0", fl[3]); else passes++;
        do_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0000);
        checks++; if (res !== 32'h0 || fl[3] !== 1'b1) $display("FAIL nota_result got %h z %b exp 00000000 z 1", res, fl[3]); else passes++;
    endtask

    task automatic test_backpressure();
        logic [31:0] r0;
        logic [3:0]  f0;
        logic [31:0] x_exp;
        logic [3:0]  x_flags;
        int n;
        ref_op(3'd0, 32'h0000_FFFF, 32'h0000_0001, er, ef);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'h0000_FFFF; req_b = 32'h0000_0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        r0 = rsp_result;
        f0 = rsp_flags;
        checks++; if (r0 !== 32'h0001_0000 || f0 !== 4'b0000) $display("FAIL bp_first got %h/%b exp 00010000/0000", r0, f0); else passes++;
        // Offer a new request while the response is held off
        ref_op(3'd4, 32'hA5A5_5A5A, 32'hFFFF_0000, x_exp, x_flags);
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'hA5A5_5A5A; req_b = 32'hFFFF_0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_result !== r0 || rsp_flags !== f0) $display("FAIL bp_stable cyc %0d got %h/%b exp %h/%b", i, rsp_result, rsp_flags, r0, f0); else passes++;
            checks++; if (alu_wf !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b1) $display("FAIL bp_ctrl cyc %0d wf %b rdy %b vld %b exp 0 0 1", i, alu_wf, req_ready, rsp_valid); else passes++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release vld %b rdy %b exp 0 1", rsp_valid, req_ready); else passes++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || alu_wf !== 1'b1) $display("FAIL bp_accept rdy %b wf %b exp 0 1", req_ready, alu_wf); else passes++;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (rsp_result !== x_exp || rsp_flags !== x_flags) $display("FAIL bp_second got %h/%b exp %h/%b", rsp_result, rsp_flags, x_exp, x_flags); else passes++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [3:0]  mask;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'h0000;
            if ($urandom_range(0, 3) == 0) b = a;
            do_op(op, a, b);
            mask = (op == 3'd7) ? 4'b1101 : 4'b1111;
            checks++; if (res !== er) $display("FAIL rnd_result op %0d a %h b %h got %h exp %h", op, a, b, res, er); else passes++;
            checks++; if ((fl & mask) !== (ef & mask)) $display("FAIL rnd_flags op %0d a %h b %h got %b exp %b", op, a, b, fl, ef); else passes++;
            checks++; if (lat !== 2) $display("FAIL rnd_latency op %0d got %0d exp 2", op, lat); else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_shift();
        test_logic();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired passed %0d of %0d", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
